// File: rtl/axis_misc_uart_decoder.sv
// Serial pulse-number telemetry decoder: 10-bit characters (start, data LSB-first,
// flag, stop) assembled into NUM_BYTES-character frames and emitted as one AXI4-Stream word.
module axis_misc_uart_decoder #(
  parameter int BIT_PERIOD         = 63,
  parameter int NUM_BYTES          = 5,
  parameter int DATA_BITS          = 7,
  parameter int VALUE_SHIFT        = 4,
  parameter int M_AXIS_TDATA_WIDTH = 40
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          rx_ce,
  input  logic                          rx_data,
  input  logic                          m_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          frame_error,
  output logic                          overrun
);

  // Handshake: a word transfers on any aclk edge where m_axis_tvalid && m_axis_tready;
  // m_axis_tdata is held while tvalid=1 and tready=0, except that a newly completed
  // frame overwrites it (flagged by overrun).

  localparam int HALF   = BIT_PERIOD / 2;
  localparam int CNT_W  = $clog2(BIT_PERIOD);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int BYTE_W = $clog2(NUM_BYTES + 1);
  localparam int WORD_W = NUM_BYTES * DATA_BITS;

  localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_IDX_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BYTE_W-1:0] BYTE_FULL    = BYTE_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_FLAG  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [BYTE_W-1:0]    byte_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 flag_bit;
  logic [WORD_W-1:0]    word;

  logic                 start_edge;
  logic                 sample_tick;
  logic                 stop_tick;
  logic                 char_ok;
  logic                 frame_done;
  logic [BYTE_W-1:0]    store_idx;
  logic [BYTE_W-1:0]    next_idx;
  logic [WORD_W-1:0]    word_next;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else if (rx_ce) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_edge) state_next = S_START;
      S_START: if (sample_tick) state_next = rx_data ? S_IDLE : S_DATA;
      S_DATA:  if (sample_tick && bit_idx == BIT_IDX_LAST) state_next = S_FLAG;
      S_FLAG:  if (sample_tick) state_next = S_STOP;
      S_STOP:  if (sample_tick) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_edge  = 1'b0;
    sample_tick = 1'b0;
    case (state)
      S_IDLE:  start_edge  = rx_ce && rx_prev && !rx_data;
      S_START: sample_tick = rx_ce && (cnt == HALF_LAST);
      default: sample_tick = rx_ce && (cnt == BIT_LAST);
    endcase
    stop_tick = sample_tick && (state == S_STOP);

    // A flag character always restarts the frame at byte 0; flag=0 is only kept mid-frame.
    store_idx  = flag_bit ? '0 : byte_idx;
    char_ok    = stop_tick && rx_data && (flag_bit || byte_idx != '0);
    next_idx   = store_idx + BYTE_W'(1);
    frame_done = char_ok && (next_idx == BYTE_FULL);
    word_next  = word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (char_ok && store_idx == BYTE_W'(b)) begin
        word_next[b*DATA_BITS +: DATA_BITS] = shreg;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_prev  <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      flag_bit <= 1'b0;
      word     <= '0;
    end else if (rx_ce) begin
      rx_prev <= rx_data;
      if (state == S_IDLE || sample_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == S_START) begin
        bit_idx <= '0;
      end
      if (sample_tick && state == S_DATA) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (bit_idx == BIT_W'(i)) shreg[i] <= rx_data;
        end
        bit_idx <= bit_idx + BIT_W'(1);
      end
      if (sample_tick && state == S_FLAG) begin
        flag_bit <= rx_data;
      end
      if (stop_tick) begin
        word <= word_next;
        if (!rx_data) begin
          byte_idx <= '0;
        end else if (char_ok) begin
          byte_idx <= frame_done ? '0 : next_idx;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_error <= stop_tick && !rx_data;
      overrun     <= frame_done && m_axis_tvalid && !m_axis_tready;
      if (frame_done) begin
        m_axis_tdata  <= M_AXIS_TDATA_WIDTH'(word_next) << VALUE_SHIFT;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_misc_uart_decoder.sv
// Bench for axis_misc_uart_decoder: serial characters driven on rx_ce ticks,
// decoded words checked against a queue of expected values.
module tb_axis_misc_uart_decoder;

  localparam int BP   = 63;
  localparam int HALF = BP / 2;
  localparam int TW   = 40;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          rx_ce;
  logic          rx_data;
  logic          m_axis_tready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          frame_error;
  logic          overrun;

  int n_cmp   = 0;
  int n_err   = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int ce_div  = 1;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] exp_w;

  axis_misc_uart_decoder dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .rx_ce         (rx_ce),
    .rx_data       (rx_data),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted word is popped and compared
  always @(negedge aclk) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got %h, required no word", m_axis_tdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_axis_tdata !== exp_w) begin
          n_err++;
          $display("FAIL word: got %h, required %h", m_axis_tdata, exp_w);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_tick(input logic b);
    repeat (ce_div - 1) @(posedge aclk);
    @(negedge aclk);
    rx_ce   = 1'b1;
    rx_data = b;
    @(posedge aclk);
    #1 rx_ce = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) drive_tick(1'b1);
  endtask

  task automatic send_char(input logic [6:0] d, input logic flag, input logic stop,
                           input int npad, input logic chk_lat);
    logic [9:0] chr;
    chr = {stop, flag, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < BP; k++) begin
        drive_tick(chr[j]);
        if (chk_lat && j == 9 && k == HALF - 1) begin
          n_cmp++;
          if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL tvalid_early: got %b, required 0", m_axis_tvalid);
          end
        end
        if (chk_lat && j == 9 && k == HALF) begin
          n_cmp++;
          if (m_axis_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL tvalid_rise: got %b, required 1", m_axis_tvalid);
          end
        end
      end
    end
    idle_ticks(npad * BP);
  endtask

  task automatic send_frame(input logic [34:0] val, input int npad, input logic push,
                            input logic chk_lat);
    logic [6:0] ch;
    for (int k = 0; k < 5; k++) begin
      ch = 7'(val >> (7 * k));
      if (k == 4 && push) exp_q.push_back(TW'(val) << 4);
      send_char(ch, k == 0, 1'b1, npad, chk_lat && k == 4);
    end
  endtask

  task automatic wait_empty(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge aclk);
      c++;
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [34:0] rand_val();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[34:0];
  endfunction

  // scenarios
  task automatic test_reset();
    aresetn       = 1'b0;
    rx_ce         = 1'b0;
    rx_data       = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp += 4;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid); end
    if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h, required 0", m_axis_tdata); end
    if (frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error: got %b, required 0", frame_error); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    aresetn = 1'b1;
    idle_ticks(5);
  endtask

  task automatic test_basic(input int div);
    logic [34:0] val;
    int fe0;
    ce_div = div;
    fe0 = fe_cnt;
    val = (35'h01 << 28) | (35'h00 << 21) | (35'h7F << 14) | (35'h2A << 7) | 35'h15;
    send_frame(val, 1, 1'b1, 1'b1);
    idle_ticks(10);
    wait_empty(50);
    n_cmp++;
    if (fe_cnt !== fe0) begin
      n_err++;
      $display("FAIL basic_no_frame_error: got %0d, required %0d", fe_cnt, fe0);
    end
    ce_div = 1;
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = fe_cnt;
    send_char(7'h15, 1'b1, 1'b1, 1, 1'b0);
    send_char(7'h2A, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h7F, 1'b0, 1'b0, 1, 1'b0);
    send_char(7'h00, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h01, 1'b0, 1'b1, 1, 1'b0);
    n_cmp += 2;
    if (fe_cnt !== fe0 + 1) begin n_err++; $display("FAIL frame_error_count: got %0d, required %0d", fe_cnt - fe0, 1); end
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL frame_error_no_word: got %b, required 0", m_axis_tvalid); end
    send_frame(rand_val(), 1, 1'b1, 1'b0);
    wait_empty(50);
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    repeat (10) drive_tick(1'b0);
    idle_ticks(100);
    n_cmp += 2;
    if (fe_cnt !== fe0) begin n_err++; $display("FAIL glitch_error: got %0d, required 0", fe_cnt - fe0); end
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL glitch_word: got %b, required 0", m_axis_tvalid); end
    send_frame(rand_val(), 1, 1'b1, 1'b0);
    wait_empty(50);
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    m_axis_tready = 1'b0;
    send_frame(35'd5, 1, 1'b0, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL overrun_first_valid: got %b, required 1", m_axis_tvalid); end
    send_frame(35'd9, 1, 1'b1, 1'b0);
    n_cmp += 3;
    if (ov_cnt !== ov0 + 1) begin n_err++; $display("FAIL overrun_count: got %0d, required 1", ov_cnt - ov0); end
    if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL overrun_valid: got %b, required 1", m_axis_tvalid); end
    if (m_axis_tdata !== 40'h90) begin n_err++; $display("FAIL overrun_tdata: got %h, required %h", m_axis_tdata, 40'h90); end
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    wait_empty(10);
    @(posedge aclk);
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL overrun_drained: got %b, required 0", m_axis_tvalid); end
  endtask

  task automatic test_hunting();
    send_char(7'h11, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h22, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h33, 1'b0, 1'b1, 1, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL hunting_idle: got %b, required 0", m_axis_tvalid); end
    send_frame(rand_val(), 1, 1'b1, 1'b0);
    wait_empty(50);
  endtask

  task automatic test_restart();
    logic [6:0] r [5];
    send_char(7'h55, 1'b1, 1'b1, 1, 1'b0);
    send_char(7'h66, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h77, 1'b0, 1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) r[k] = 7'($urandom_range(0, 127));
    for (int k = 0; k < 4; k++) send_char(r[k], k == 0, 1'b1, 1, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL restart_hold: got %b, required 0", m_axis_tvalid); end
    exp_q.push_back(TW'({r[4], r[3], r[2], r[1], r[0]}) << 4);
    send_char(r[4], 1'b0, 1'b1, 1, 1'b0);
    wait_empty(50);
  endtask

  task automatic test_reset_mid();
    send_char(7'h0F, 1'b1, 1'b1, 1, 1'b0);
    send_char(7'h70, 1'b0, 1'b1, 1, 1'b0);
    repeat (200) drive_tick(1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    idle_ticks(BP);
    send_char(7'h01, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h02, 1'b0, 1'b1, 1, 1'b0);
    send_char(7'h03, 1'b0, 1'b1, 1, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b, required 0", m_axis_tvalid); end
  endtask

  task automatic test_back_to_back();
    send_frame(rand_val(), 0, 1'b1, 1'b0);
    send_frame(rand_val(), 0, 1'b1, 1'b0);
    idle_ticks(10);
    wait_empty(50);
  endtask

  initial begin
    test_reset();
    test_basic(1);
    test_basic(3);
    test_frame_error();
    test_glitch();
    test_overrun();
    test_hunting();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
